snoop_cache_ctrl: RTL and testbench

SNOOP_CACHE_CTRL -- requirements
Module: snoop_cache_ctrl

---
 rtl/snoop_cache_ctrl_if.sv | 27 ++
 rtl/snoop_cache_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_snoop_cache_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snoop_cache_ctrl_if.sv
// snoop_cache_ctrl_if: request/response and snoop bus signals of one cache
// controller. The master side is whoever drives requests and the shared bus.
interface snoop_cache_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) ();
  localparam int BUS_W = 6 + ADDR_W + DATA_W;

  logic              execute_instruction;
  logic              instruction;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [BUS_W-1:0]  bus_in;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic [BUS_W-1:0]  bus_out;

  modport master (
    output execute_instruction, instruction, address, data_in, bus_in,
    input  data_out, done, bus_out
  );

  modport slave (
    input  execute_instruction, instruction, address, data_in, bus_in,
    output data_out, done, bus_out
  );
endinterface

// File: rtl/snoop_cache_ctrl.sv
// snoop_cache_ctrl: direct-mapped MSI cache controller with bus snooping.
// Bus word, MSB first: write_back, abort, ack, read_miss, write_miss,
// invalidate, addr, data. Snoops are served only in IDLE and WAIT.
// Define SNOOP_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module snoop_cache_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int LINES  = 2
) (
  input  logic clock,
  input  logic reset_n,
  snoop_cache_ctrl_if.slave cif
`ifdef SNOOP_CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam logic [1:0] MSI_I = 2'b00;
  localparam logic [1:0] MSI_S = 2'b01;
  localparam logic [1:0] MSI_M = 2'b10;

  typedef struct packed {
    logic              wb;
    logic              abort;
    logic              ack;
    logic              rd_miss;
    logic              wr_miss;
    logic              inval;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bus_msg_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_ISSUE, S_WAIT, S_UPDATE
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  // captured request
  logic              req_wr_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q;

  // line storage: MSI state, full-address tag, data
  logic [LINES-1:0][1:0]        st_q,  st_d;
  logic [LINES-1:0][ADDR_W-1:0] tag_q, tag_d;
  logic [LINES-1:0][DATA_W-1:0] dat_q, dat_d;

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              done_q, done_d;
  bus_msg_t          bus_out_q, bus_out_d;

  bus_msg_t          snp;
  logic [IDX_W-1:0]  req_idx, snp_idx;
  logic              accept, hit, snp_req, snp_hit, fill;
  logic              abort_unused;

  assign snp          = bus_msg_t'(cif.bus_in);
  // incoming abort carries no meaning for this controller
  assign abort_unused = snp.abort;
  assign req_idx      = req_addr_q[IDX_W-1:0];
  assign snp_idx      = snp.addr[IDX_W-1:0];
  assign accept       = (fsm_q == S_IDLE) && cif.execute_instruction && done_q;
  assign hit          = (st_q[req_idx] != MSI_I) && (tag_q[req_idx] == req_addr_q);
  assign snp_req      = snp.rd_miss | snp.wr_miss | snp.inval;
  assign snp_hit      = ((fsm_q == S_IDLE) || (fsm_q == S_WAIT)) && snp_req &&
                        (st_q[snp_idx] != MSI_I) && (tag_q[snp_idx] == snp.addr);
  assign fill         = snp.ack | snp.wb;

  assign cif.data_out = data_out_q;
  assign cif.done     = done_q;
  assign cif.bus_out  = bus_out_q;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fsm_q <= S_IDLE;
    else          fsm_q <= fsm_d;
  end

  // FSM next-state
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE:   if (accept) fsm_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit) begin
          if (!req_wr_q)                   fsm_d = S_IDLE;
          else if (st_q[req_idx] == MSI_M) fsm_d = S_UPDATE;
          else                             fsm_d = S_ISSUE;
        end else if (st_q[req_idx] == MSI_M) begin
          fsm_d = S_EVICT;
        end else begin
          fsm_d = S_ISSUE;
        end
      end
      S_EVICT:  fsm_d = S_ISSUE;
      S_ISSUE:  fsm_d = req_wr_q ? S_UPDATE : S_WAIT;
      S_WAIT:   if (fill) fsm_d = S_UPDATE;
      S_UPDATE: fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  // FSM outputs and line updates; bus messages are one-cycle pulses.
  // Snoop updates are applied first so a fill in WAIT wins on its own line.
  always_comb begin
    st_d       = st_q;
    tag_d      = tag_q;
    dat_d      = dat_q;
    data_out_d = data_out_q;
    done_d     = done_q;
    bus_out_d  = '0;

    if (snp_hit) begin
      if (snp.rd_miss) begin
        bus_out_d.addr = snp.addr;
        bus_out_d.data = dat_q[snp_idx];
        if (st_q[snp_idx] == MSI_M) begin
          bus_out_d.wb  = 1'b1;
          st_d[snp_idx] = MSI_S;
        end else begin
          bus_out_d.ack = 1'b1;
        end
      end else if (snp.wr_miss) begin
        st_d[snp_idx] = MSI_I;
        if (st_q[snp_idx] == MSI_M) begin
          bus_out_d.wb   = 1'b1;
          bus_out_d.addr = snp.addr;
          bus_out_d.data = dat_q[snp_idx];
        end
      end else if (st_q[snp_idx] == MSI_S) begin
        st_d[snp_idx]  = MSI_I;
        bus_out_d.ack  = 1'b1;
        bus_out_d.addr = snp.addr;
      end
    end

    unique case (fsm_q)
      S_IDLE: if (accept) done_d = 1'b0;
      S_LOOKUP: begin
        if (hit) begin
          if (!req_wr_q) begin
            data_out_d = dat_q[req_idx];
            done_d     = 1'b1;
          end else if (st_q[req_idx] == MSI_M) begin
            dat_d[req_idx] = req_data_q;
          end
        end else if (st_q[req_idx] == MSI_M) begin
          // dirty victim goes out now; the line is dead until refilled
          bus_out_d.wb   = 1'b1;
          bus_out_d.addr = tag_q[req_idx];
          bus_out_d.data = dat_q[req_idx];
          st_d[req_idx]  = MSI_I;
        end
      end
      S_ISSUE: begin
        // only a write hit in S can still hit here; that becomes an invalidate
        bus_out_d.addr = req_addr_q;
        if (hit)           bus_out_d.inval   = 1'b1;
        else if (req_wr_q) bus_out_d.wr_miss = 1'b1;
        else               bus_out_d.rd_miss = 1'b1;
        if (req_wr_q) begin
          st_d[req_idx]  = MSI_M;
          tag_d[req_idx] = req_addr_q;
          dat_d[req_idx] = req_data_q;
        end
      end
      S_WAIT: begin
        if (fill) begin
          st_d[req_idx]  = MSI_S;
          tag_d[req_idx] = req_addr_q;
          dat_d[req_idx] = snp.data;
        end
      end
      S_UPDATE: begin
        data_out_d = dat_q[req_idx];
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // line storage and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q       <= '0;
      tag_q      <= '0;
      dat_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b1;
      bus_out_q  <= '0;
    end else begin
      st_q       <= st_d;
      tag_q      <= tag_d;
      dat_q      <= dat_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      bus_out_q  <= bus_out_d;
    end
  end

  // request capture on accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else if (accept) begin
      req_wr_q   <= cif.instruction;
      req_addr_q <= cif.address;
      req_data_q <= cif.data_in;
    end
  end

`ifdef SNOOP_CACHE_STATS_EN
  // saturating hit/miss counters, one count per lookup
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (fsm_q == S_LOOKUP) begin
      if (hit && (hit_count != 16'hFFFF))
        hit_count <= hit_count + 16'd1;
      else if (!hit && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// tb_snoop_cache_ctrl: directed + random stimulus against a line-array model;
// expected bus messages and read/write results go into queues and a monitor
// compares them as the controller produces them.
module tb_snoop_cache_ctrl;
  localparam int AW = 3;
  localparam int DW = 4;
  localparam int LINES = 2;
  localparam int BW = 6 + AW + DW;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  snoop_cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) cif ();

`ifdef SNOOP_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
  snoop_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINES(LINES)) dut (
    .clock(clock), .reset_n(reset_n), .cif(cif),
    .hit_count(hit_count), .miss_count(miss_count));
`else
  snoop_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINES(LINES)) dut (
    .clock(clock), .reset_n(reset_n), .cif(cif));
`endif

  int n_vec = 0;
  int n_bad = 0;

  // model: 0=I 1=S 2=M per line
  int            m_st [LINES];
  logic [AW-1:0] m_tag[LINES];
  logic [DW-1:0] m_dat[LINES];

  logic [BW-1:0] exp_bus[$];
  logic [DW-1:0] exp_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] msg(input bit wb, input bit ack, input bit rm,
                                        input bit wm, input bit inv,
                                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {wb, 1'b0, ack, rm, wm, inv, a, d};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) begin
      m_st[i] = 0; m_tag[i] = '0; m_dat[i] = '0;
    end
  endfunction

  // t: 0 none, 1 read_miss, 2 write_miss, 3 invalidate
  function automatic void model_snoop(input int t, input logic [AW-1:0] a);
    int i;
    i = int'(a) % LINES;
    if (t == 0 || m_st[i] == 0 || m_tag[i] != a) return;
    case (t)
      1: if (m_st[i] == 2) begin exp_bus.push_back(msg(1,0,0,0,0,a,m_dat[i])); m_st[i] = 1; end
         else exp_bus.push_back(msg(0,1,0,0,0,a,m_dat[i]));
      2: begin
           if (m_st[i] == 2) exp_bus.push_back(msg(1,0,0,0,0,a,m_dat[i]));
           m_st[i] = 0;
         end
      default: if (m_st[i] == 1) begin exp_bus.push_back(msg(0,1,0,0,0,a,'0)); m_st[i] = 0; end
    endcase
  endfunction

  // an invalidate against a modified copy is not a legal bus event
  function automatic int fix_t(input int t, input logic [AW-1:0] a);
    int i;
    i = int'(a) % LINES;
    if (t == 3 && m_st[i] == 2 && m_tag[i] == a) return 1;
    return t;
  endfunction

  function automatic void model_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [DW-1:0] fd, input bit abort,
                                    output bit rd_hit, output bit fill);
    int i;
    bit h;
    i = int'(a) % LINES;
    h = (m_st[i] != 0) && (m_tag[i] == a);
    rd_hit = 0; fill = 0;
    if (h && !w) begin
      rd_hit = 1; exp_data.push_back(m_dat[i]);
    end else if (h && m_st[i] == 2) begin
      m_dat[i] = d; exp_data.push_back(d);
    end else if (h) begin
      exp_bus.push_back(msg(0,0,0,0,1,a,'0));
      m_st[i] = 2; m_dat[i] = d; exp_data.push_back(d);
    end else begin
      if (m_st[i] == 2) exp_bus.push_back(msg(1,0,0,0,0,m_tag[i],m_dat[i]));
      if (w) begin
        exp_bus.push_back(msg(0,0,0,1,0,a,'0));
        m_st[i] = 2; m_tag[i] = a; m_dat[i] = d; exp_data.push_back(d);
      end else begin
        exp_bus.push_back(msg(0,0,1,0,0,a,'0));
        fill = 1;
        if (!abort) begin
          m_st[i] = 1; m_tag[i] = a; m_dat[i] = fd; exp_data.push_back(fd);
        end
      end
    end
  endfunction

  task automatic do_abort();
    #1 reset_n = 1'b0;
    @(negedge clock);
    chk("abort_done", cif.done, 1);
    chk("abort_bus_out", cif.bus_out, 0);
    chk("abort_data_out", cif.data_out, 0);
    @(negedge clock);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] fd, input bit abort,
                        input int st, input logic [AW-1:0] sa, input bit junk);
    bit rd_hit, fill, filled, fin;
    model_snoop(st, sa);
    model_req(w, a, d, fd, abort, rd_hit, fill);
    @(negedge clock);
    cif.execute_instruction = 1'b1;
    cif.instruction = w;
    cif.address = a;
    cif.data_in = d;
    if (st != 0) cif.bus_in = msg(0,0,st==1,st==2,st==3,sa,DW'($urandom));
    @(negedge clock);
    cif.execute_instruction = 1'b0;
    cif.bus_in = '0;
    chk("busy_after_accept", cif.done, 0);
    if (junk) begin
      cif.execute_instruction = 1'b1;
      cif.instruction = 1'($urandom);
      cif.address = AW'($urandom);
      cif.data_in = DW'($urandom);
    end
    filled = 0; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clock);
      cif.execute_instruction = 1'b0;
      cif.bus_in = '0;
      if (rd_hit && c == 0) chk("read_hit_latency", cif.done, 1);
      if (cif.done) fin = 1;
      else if (fill && !filled && cif.bus_out[BW-4]) begin
        filled = 1;
        if (abort) begin
          do_abort();
          return;
        end
        cif.bus_in = msg(0,1,0,0,0,a,fd);
      end
    end
    if (!fin) chk("request_timeout", 0, 1);
  endtask

  task automatic do_snoop(input int t, input logic [AW-1:0] a);
    model_snoop(t, a);
    @(negedge clock);
    cif.bus_in = msg(0,0,t==1,t==2,t==3,a,DW'($urandom));
    @(negedge clock);
    cif.bus_in = '0;
    @(negedge clock);
  endtask

  // monitor: every bus message and every completion is checked in order
  bit prev_done = 1'b1;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_done = 1'b1;
    end else begin
      if (cif.bus_out != '0) begin
        if (exp_bus.size() == 0) chk("bus_unexpected", cif.bus_out, 0);
        else chk("bus_msg", cif.bus_out, exp_bus.pop_front());
      end
      if (cif.done && !prev_done) begin
        if (exp_data.size() == 0) chk("done_unexpected", 1, 0);
        else chk("data_out", cif.data_out, exp_data.pop_front());
      end
      prev_done = cif.done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t, ln;
    bit w, ab;
    logic [AW-1:0] a, sa;
    cif.execute_instruction = 1'b0;
    cif.instruction = 1'b0;
    cif.address = '0;
    cif.data_in = '0;
    cif.bus_in = '0;
    model_clear();
    repeat (2) @(negedge clock);
    chk("reset_done", cif.done, 1);
    chk("reset_bus_out", cif.bus_out, 0);
    chk("reset_data_out", cif.data_out, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_done", cif.done, 1);
    chk("idle_bus_out", cif.bus_out, 0);

    // directed walk
    do_req(0, 3'b010, '0,   4'hA, 0, 0, '0, 0);   // read miss, fill A
    do_req(0, 3'b010, '0,   '0,   0, 0, '0, 0);   // read hit
    do_req(1, 3'b010, 4'h5, '0,   0, 0, '0, 0);   // write hit S -> invalidate
    do_req(1, 3'b000, 4'h7, '0,   0, 0, '0, 0);   // evict 010/5, write miss 000
    do_snoop(1, 3'b000);                          // write_back 7, line S
    do_snoop(3, 3'b000);                          // ack, line I
    do_req(0, 3'b010, '0,   4'h3, 1, 0, '0, 0);   // reset during WAIT
    do_req(0, 3'b010, '0,   4'hC, 0, 0, '0, 0);   // misses again after reset

    // random traffic
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      a = AW'($urandom);
      ln = $urandom_range(0, LINES - 1);
      sa = ($urandom_range(0, 1) == 1) ? m_tag[ln] : AW'($urandom);
      if (r < 6) begin
        w = 1'($urandom);
        ab = ($urandom_range(0, 29) == 0);
        t = ($urandom_range(0, 3) == 0) ? fix_t($urandom_range(1, 3), sa) : 0;
        do_req(w, a, DW'($urandom), DW'($urandom), ab, t, sa, 1'($urandom));
      end else begin
        do_snoop(fix_t($urandom_range(1, 3), sa), sa);
      end
    end

    repeat (5) @(negedge clock);
    chk("bus_queue_drained", exp_bus.size(), 0);
    chk("data_queue_drained", exp_data.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
